// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider with pipeline stall control.
// One quotient bit per cycle, MSB first. Results are registered on entry to DONE
// and held until the next completed divide.
// Optional build macro SIGNED_DIV_EN: two's-complement operands, with the
// division run on magnitudes and the sign fixed up combinationally at the output.
//
// state | meaning
// IDLE  | waiting for a Divide opcode; the accept cycle raises stall
// CALC  | one restoring step per cycle, counter WIDTH-1 down to 0
// DONE  | one-cycle write-back strobe, results valid
module div_sequencer #(
  parameter int          WIDTH      = 32,
  parameter logic [3:0]  DIV_OPCODE = 4'b1011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [3:0]       dest_reg,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       dest_reg_out,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] qsh;
  logic [WIDTH-1:0] dsr;
  logic [3:0]       dst;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic [3:0]       dst_out;
  logic             dbz_out;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;

`ifdef SIGNED_DIV_EN
  logic a_neg, b_neg;
  logic op_nq, op_nr;
  logic out_nq, out_nr;
  assign a_neg = dividend[WIDTH-1];
  assign b_neg = divisor[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  assign div_zero = (divisor == '0);

  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  assign shifted  = {prem[WIDTH-1:0], qsh[WIDTH-1]};
  assign diff     = shifted - {1'b0, dsr};
  assign ge       = (shifted >= {1'b0, dsr});
  assign rem_step = ge ? diff : shifted;
  assign q_step   = {qsh[WIDTH-2:0], ge};

  // Next-state and control outputs; flush overrides every transition.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    stall        = 1'b0;
    busy         = (state != IDLE);
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid && (opcode == DIV_OPCODE) && !flush && rst_n) begin
          accept    = 1'b1;
          stall     = 1'b1;
          state_nxt = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
    if (!rst_n) stall = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, iteration datapath and held result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      prem    <= '0;
      qsh     <= '0;
      dsr     <= '0;
      dst     <= '0;
      q_out   <= '0;
      r_out   <= '0;
      dst_out <= '0;
      dbz_out <= 1'b0;
`ifdef SIGNED_DIV_EN
      op_nq   <= 1'b0;
      op_nr   <= 1'b0;
      out_nq  <= 1'b0;
      out_nr  <= 1'b0;
`endif
    end else if (accept) begin
      prem <= '0;
      qsh  <= a_mag;
      dsr  <= b_mag;
      dst  <= dest_reg;
      cnt  <= div_zero ? '0 : CW'(WIDTH - 1);
`ifdef SIGNED_DIV_EN
      op_nq <= a_neg ^ b_neg;
      op_nr <= a_neg;
`endif
      if (div_zero) begin
        q_out   <= '1;
        r_out   <= a_mag;
        dst_out <= dest_reg;
        dbz_out <= 1'b1;
`ifdef SIGNED_DIV_EN
        out_nq  <= 1'b0;
        out_nr  <= a_neg;
`endif
      end
    end else if ((state == CALC) && !flush) begin
      prem <= rem_step;
      qsh  <= q_step;
      cnt  <= (cnt == '0) ? '0 : cnt - 1'b1;
      if (cnt == '0) begin
        q_out   <= q_step;
        r_out   <= rem_step[WIDTH-1:0];
        dst_out <= dst;
        dbz_out <= 1'b0;
`ifdef SIGNED_DIV_EN
        out_nq  <= op_nq;
        out_nr  <= op_nr;
`endif
      end
    end
  end

`ifdef SIGNED_DIV_EN
  assign quotient  = out_nq ? -q_out : q_out;
  assign remainder = out_nr ? -r_out : r_out;
`else
  assign quotient  = q_out;
  assign remainder = r_out;
`endif
  assign dest_reg_out = dst_out;
  assign div_by_zero  = dbz_out;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and randomized cycle-level checks of div_sequencer
// against a transaction-level reference (arithmetic / and %, cycle countdown).
module tb_div_sequencer;

  localparam int         WIDTH = 32;
  localparam logic [3:0] DIV   = 4'b1011;

  logic             clk = 1'b0;
  logic             rst_n, op_valid, flush;
  logic [3:0]       opcode, dest_reg;
  logic [WIDTH-1:0] dividend, divisor;
  logic             stall, busy, result_valid, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;
  logic [3:0]       dest_reg_out;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  bit        m_busy;
  int        m_rem;
  bit [31:0] pq, pr, hq, hr;
  bit [3:0]  pd, hd;
  bit        pz, hz;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(WIDTH), .DIV_OPCODE(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .opcode(opcode),
    .dividend(dividend), .divisor(divisor), .dest_reg(dest_reg), .flush(flush),
    .stall(stall), .busy(busy), .result_valid(result_valid),
    .quotient(quotient), .remainder(remainder), .dest_reg_out(dest_reg_out),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", tag, $time, obs, exp);
    end
  endtask

  function automatic void ref_div(input bit [31:0] a, input bit [31:0] b,
                                  output bit [31:0] q, output bit [31:0] r, output bit z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // One clock cycle: drive after the edge, check mid-cycle, then advance the model.
  task automatic step(input bit ov, input bit [3:0] opc, input bit [31:0] a, input bit [31:0] b,
                      input bit [3:0] d, input bit fl, input bit rn);
    bit acc;
    bit [31:0] q, r;
    bit z;
    @(posedge clk); #1;
    op_valid = ov; opcode = opc; dividend = a; divisor = b; dest_reg = d;
    flush = fl; rst_n = rn;
    acc = rn && !m_busy && ov && (opc == DIV) && !fl;
    #4;
    chk("stall",        32'(stall),        32'(rn && (acc || (m_busy && m_rem > 0))));
    chk("busy",         32'(busy),         32'(m_busy));
    chk("result_valid", 32'(result_valid), 32'(m_busy && m_rem == 0));
    chk("quotient",     quotient,          hq);
    chk("remainder",    remainder,         hr);
    chk("dest_reg_out", 32'(dest_reg_out), 32'(hd));
    chk("div_by_zero",  32'(div_by_zero),  32'(hz));
    if (!rn) begin
      m_busy = 0; hq = 0; hr = 0; hd = 0; hz = 0;
    end else if (fl) begin
      m_busy = 0;
    end else if (acc) begin
      ref_div(a, b, q, r, z);
      pq = q; pr = r; pz = z; pd = d;
      m_busy = 1;
      if (b == 0) begin
        m_rem = 0; hq = pq; hr = pr; hd = pd; hz = pz;
      end else begin
        m_rem = WIDTH;
      end
    end else if (m_busy) begin
      if (m_rem == 0) m_busy = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin hq = pq; hr = pr; hd = pd; hz = pz; end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    bit [31:0] a, b;
    bit [3:0]  opc;
    rst_n = 0; op_valid = 0; opcode = 0; dividend = 0; divisor = 0; dest_reg = 0; flush = 0;
    m_busy = 0; m_rem = 0; hq = 0; hr = 0; hd = 0; hz = 0; pq = 0; pr = 0; pd = 0; pz = 0;
    repeat (2) @(posedge clk);
    step(0, 4'h0, 0, 0, 0, 0, 0);           // reset state
    step(0, 4'h0, 0, 0, 0, 0, 1);

    // 100/7 into r3, then all-ones/1
    step(1, DIV, 100, 7, 3, 0, 1);          idle(35);
    step(1, DIV, 32'hFFFF_FFFF, 1, 5, 0, 1); idle(35);
    // divide by zero, one-cycle latency
    step(1, DIV, 55, 0, 9, 0, 1);           idle(3);
    // flush in cycle 10, new accept in cycle 11
    step(1, DIV, 100, 7, 2, 0, 1);          idle(9);
    step(0, 4'h0, 0, 0, 0, 1, 1);
    step(1, DIV, 1000, 9, 6, 0, 1);         idle(35);
    // reset in cycle 5 abandons the operation
    step(1, DIV, 12345, 17, 4, 0, 1);       idle(4);
    step(0, 4'h0, 0, 0, 0, 0, 0);           idle(3);
    // non-Divide opcode never stalls
    for (int i = 0; i < 4; i++) step(1, 4'b1000, 77, 3, 1, 0, 1);
    // flush against a would-be accept
    step(1, DIV, 77, 3, 1, 1, 1);           idle(2);
    // flush in DONE keeps that cycle's strobe
    step(1, DIV, 8, 0, 7, 0, 1);
    step(0, 4'h0, 0, 0, 0, 1, 1);           idle(2);
    // op_valid ignored while busy
    step(1, DIV, 999, 10, 8, 0, 1);
    for (int i = 0; i < 34; i++) step(1, DIV, 5, 1, 15, 0, 1);
    idle(3);
`ifdef SIGNED_DIV_EN
    step(1, DIV, 32'hFFFF_FFF9, 2, 1, 0, 1);            idle(35);
    step(1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, 1); idle(35);
    step(1, DIV, 32'h0000_0007, 32'hFFFF_FFFE, 3, 0, 1); idle(35);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = $urandom & 32'h0000_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = a & 32'hFF;
`ifdef SIGNED_DIV_EN
      if ($urandom_range(0, 31) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
`endif
      opc = ($urandom_range(0, 3) != 0) ? DIV : 4'($urandom);
      step(bit'($urandom_range(0, 1)), opc, a, b, 4'($urandom),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) != 0));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits (SHALL be 4..32).
REQ-002 Parameter: DIV_OPCODE, default 4'b1011, the Divide opcode this block accepts.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 op_valid  input  1  execute stage holds a valid instruction this cycle.
REQ-006 opcode  input  4  opcode of that instruction.
REQ-007 dividend  input  WIDTH  operand A, sampled on accept.
REQ-008 divisor  input  WIDTH  operand B, sampled on accept.
REQ-009 dest_reg  input  4  destination register index, sampled on accept.
REQ-010 flush  input  1  pipeline flush; aborts any operation in progress.
REQ-011 stall  output  1  freezes fetch, decode and execute while a divide is in progress.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 result_valid  output  1  one-cycle write-back strobe to the register file.
REQ-014 quotient  output  WIDTH  result for write-back.
REQ-015 remainder  output  WIDTH  remainder result.
REQ-016 dest_reg_out  output  4  register index paired with result_valid.
REQ-017 div_by_zero  output  1  qualifies result_valid; divisor was zero.

Function
REQ-018 The block SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-019 Accept SHALL occur when state==IDLE && op_valid && opcode==DIV_OPCODE && !flush.
- On accept, the block SHALL latch the operands and dest_reg.
REQ-020 Transitions from IDLE on accept SHALL be:
- divisor!=0: go to CALC with the bit counter = WIDTH-1.
- divisor==0: go directly to DONE.
REQ-021 Division SHALL be restoring, unsigned, one quotient bit per cycle, MSB first.
- Partial remainder width SHALL be WIDTH+1.
REQ-022 CALC SHALL decrement the counter each cycle and go to DONE after the cycle in which counter==0.
- CALC therefore lasts exactly WIDTH cycles.
REQ-023 DONE SHALL last one cycle and then return to IDLE.
- In DONE: result_valid=1, and quotient, remainder, dest_reg_out and div_by_zero are valid.
REQ-024 Latency with accept in cycle 0 SHALL be:
- Nonzero divisor: result_valid in cycle WIDTH+1.
- Zero divisor: result_valid in cycle 1.
REQ-025 stall SHALL be combinational:
- High in the accept cycle and in every CALC cycle.
- Low in DONE and in IDLE without an accept.
REQ-026 When not in DONE, result_valid SHALL be 0 and quotient, remainder and dest_reg_out SHALL hold their last values.
REQ-027 Divide by zero SHALL give quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-028 op_valid SHALL be ignored while busy; no queueing.
REQ-029 flush in any state SHALL force IDLE on the next edge, and no result_valid SHALL follow.
- flush in DONE SHALL NOT suppress that cycle's result_valid, which is already asserted.
REQ-030 flush coincident with a would-be accept SHALL win: no accept and no stall.
REQ-031 A non-Divide opcode SHALL never assert stall or busy.

Reset
REQ-032 While rst_n==0 at a clock edge, the block SHALL go to IDLE with counter=0.
- stall, busy, result_valid and div_by_zero SHALL be 0.
- quotient, remainder and dest_reg_out SHALL be 0.
REQ-033 Reset during CALC or DONE SHALL abandon the operation with no result_valid.
- Reset SHALL have priority over flush and accept.

Configuration
REQ-034 Macro SIGNED_DIV_EN defined: operands SHALL be two's-complement signed.
- Division SHALL run on magnitudes, with sign correction applied combinationally at the output.
- Quotient SHALL truncate toward zero; remainder SHALL take the dividend's sign.
- Latency SHALL be unchanged.
- Most-negative / -1 SHALL give quotient = most-negative, remainder = 0.
REQ-035 Macro SIGNED_DIV_EN undefined: the division SHALL be unsigned only, with no sign logic synthesized.

Verification (WIDTH=32)
REQ-036 dividend=100, divisor=7, dest_reg=3 -> stall high for cycles 0..32.
- Cycle 33: result_valid=1, quotient=14, remainder=2, dest_reg_out=3, div_by_zero=0.
REQ-037 dividend=0xFFFFFFFF, divisor=1 -> cycle 33: quotient=0xFFFFFFFF, remainder=0.
REQ-038 divisor=0, dividend=55 -> cycle 1: result_valid=1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=55.
- stall high only in cycle 0.
REQ-039 Accept, then flush in cycle 10 -> IDLE in cycle 11, no result_valid.
- A new accept in cycle 11 completes normally in cycle 44.
REQ-040 Accept, then rst_n=0 in cycle 5 -> all outputs 0 from cycle 6, no result_valid.
- op_valid with opcode 4'b1000 -> no stall.
REQ-041 SIGNED_DIV_EN defined: -7/2 -> quotient=-3, remainder=-1.
- 0x80000000 / -1 -> quotient=0x80000000, remainder=0.
